// File: rtl/imm_extend_pipe_pkg.sv
// Shared processor definitions for the immediate-extension path.
// Holds the extension mode encodings used by the pipe and its core.
package imm_extend_pipe_pkg;

   localparam int unsigned MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      MODE_SEXT     = 2'd0,
      MODE_ZEXT     = 2'd1,
      MODE_SEXT_SHL = 2'd2,
      MODE_UPPER    = 2'd3
   } imm_mode_e;

endpackage

// File: rtl/imm_extend_pipe_core.sv
// Combinational immediate extension: sign, zero, shifted-sign and upper-placement modes.
// Purely combinational; registered by imm_extend_pipe.
module imm_extend_core
   import imm_extend_pipe_pkg::*;
#(
   parameter int IN_W  = 17,
   parameter int OUT_W = 32,
   parameter int SHIFT = 2
) (
   input  logic [IN_W-1:0]   in_data,
   input  logic [MODE_W-1:0] in_mode,
   output logic [OUT_W-1:0]  out_data
);

   logic [OUT_W-1:0] sext;
   logic [OUT_W-1:0] zext;
   logic [OUT_W-1:0] upper;

   assign sext  = {{(OUT_W-IN_W){in_data[IN_W-1]}}, in_data};
   assign zext  = {{(OUT_W-IN_W){1'b0}}, in_data};
   assign upper = {in_data, {(OUT_W-IN_W){1'b0}}};

   always_comb begin
      out_data = '0;
      case (imm_mode_e'(in_mode))
         MODE_SEXT:     out_data = sext;
         MODE_ZEXT:     out_data = zext;
         MODE_SEXT_SHL: out_data = sext << SHIFT;
         MODE_UPPER:    out_data = upper;
         default:       out_data = '0;
      endcase
   end

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate extension with valid/ready handshake and a 2-entry in-order result buffer.
// Extension happens at accept time, so later in_mode/in_data changes never touch stored results.
module imm_extend_pipe
   import imm_extend_pipe_pkg::*;
#(
   parameter int IN_W  = 17,
   parameter int OUT_W = 32,
   parameter int SHIFT = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IN_W-1:0]   in_data,
   input  logic [MODE_W-1:0] in_mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_data
);

   logic [1:0]       count;
   logic [OUT_W-1:0] entry_head;
   logic [OUT_W-1:0] entry_tail;
   logic [OUT_W-1:0] ext;
   logic             accept;
   logic             pop;

   imm_extend_core #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .SHIFT (SHIFT)
   ) u_core (
      .in_data  (in_data),
      .in_mode  (in_mode),
      .out_data (ext)
   );

   assign in_ready  = (count < 2'd2) & ~reset;
   assign out_valid = (count != 2'd0);
   assign out_data  = entry_head;
   assign accept    = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // Head always holds the oldest result; tail is cleared on pop so an empty buffer reads zero.
   always_ff @(posedge clock) begin
      if (reset) begin
         count      <= '0;
         entry_head <= '0;
         entry_tail <= '0;
      end else begin
         case ({accept, pop})
            2'b10: begin
               if (count == 2'd0) entry_head <= ext;
               else               entry_tail <= ext;
               count <= count + 2'd1;
            end
            2'b01: begin
               entry_head <= entry_tail;
               entry_tail <= '0;
               count      <= count - 2'd1;
            end
            2'b11: begin
               // Only reachable with count==1: the popped head is replaced by the new result.
               entry_head <= ext;
               entry_tail <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed-vector bench for imm_extend_pipe (IN_W=17, OUT_W=32, SHIFT=2).
module tb_imm_extend_pipe;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [16:0] in_data;
   logic [1:0]  in_mode;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;

   int n_vec = 0;
   int n_err = 0;

   imm_extend_pipe #(
      .IN_W  (17),
      .OUT_W (32),
      .SHIFT (2)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   logic [16:0] vd [8];
   logic [1:0]  vm [8];
   logic [31:0] ve [8];
   logic [16:0] sd [11];
   logic [31:0] se [11];

   initial begin
      vd[0] = 17'h10000; vm[0] = 2'd0; ve[0] = 32'hFFFF0000;
      vd[1] = 17'h10000; vm[1] = 2'd1; ve[1] = 32'h00010000;
      vd[2] = 17'h1FFFF; vm[2] = 2'd2; ve[2] = 32'hFFFFFFFC;
      vd[3] = 17'h00001; vm[3] = 2'd3; ve[3] = 32'h00008000;
      vd[4] = 17'h1FFFF; vm[4] = 2'd3; ve[4] = 32'hFFFF8000;
      vd[5] = 17'h0FFFF; vm[5] = 2'd0; ve[5] = 32'h0000FFFF;
      vd[6] = 17'h10000; vm[6] = 2'd2; ve[6] = 32'hFFFC0000;
      vd[7] = 17'h1FFFF; vm[7] = 2'd1; ve[7] = 32'h0001FFFF;

      // SEXT stream: odd entries have the sign bit set
      for (int k = 0; k < 11; k++) begin
         sd[k] = 17'(k) | ((k % 2 == 1) ? 17'h10000 : 17'h0);
         se[k] = 32'(k) | ((k % 2 == 1) ? 32'hFFFF0000 : 32'h0);
      end

      reset = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = '0; out_ready = 1'b0;
      step(); step();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", out_data, 32'h0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      reset = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      // all modes back to back, one result per cycle
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_data = vd[i]; in_mode = vm[i];
         step();
         chk("mode_valid", 32'(out_valid), 32'd1);
         chk($sformatf("mode_vec%0d", i), out_data, ve[i]);
      end
      in_valid = 1'b0;
      step();
      chk("drain_valid", 32'(out_valid), 32'd0);

      // empty buffer ignores out_ready
      step(); step();
      chk("empty_no_underflow", 32'(out_valid), 32'd0);
      chk("empty_in_ready", 32'(in_ready), 32'd1);

      // backpressure: fill to two, third blocked
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 17'h00005; in_mode = 2'd0;
      step();
      chk("bp_ready_c1", 32'(in_ready), 32'd1);
      in_data = 17'h1FFFF; in_mode = 2'd1;
      step();
      chk("bp_ready_c2", 32'(in_ready), 32'd0);
      in_data = 17'h00003; in_mode = 2'd3;
      step();
      chk("bp_head", out_data, 32'h00000005);
      chk("bp_ready_c3", 32'(in_ready), 32'd0);

      // stall: head stable while inputs toggle
      for (int t = 0; t < 3; t++) begin
         in_data = 17'h1FFFF ^ 17'(t * 17'h0A5A5);
         in_mode = 2'(t);
         step();
         chk("stall_hold", out_data, 32'h00000005);
         chk("stall_valid", 32'(out_valid), 32'd1);
      end
      in_data = 17'h00003; in_mode = 2'd3;
      out_ready = 1'b1;
      step();
      chk("bp_second", out_data, 32'h0001FFFF);
      chk("bp_ready_after_pop", 32'(in_ready), 32'd1);
      step();
      chk("bp_third", out_data, 32'h00018000);
      in_valid = 1'b0;
      step();
      chk("bp_drained", 32'(out_valid), 32'd0);

      // count=1 with accept+pop every cycle
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = sd[0]; in_mode = 2'd0;
      step();
      out_ready = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         chk($sformatf("steady_out%0d", k - 1), out_data, se[k-1]);
         chk("steady_valid", 32'(out_valid), 32'd1);
         chk("steady_ready", 32'(in_ready), 32'd1);
         in_data = sd[k];
         step();
      end
      chk("steady_last", out_data, se[10]);
      in_valid = 1'b0;
      step();
      chk("steady_drained", 32'(out_valid), 32'd0);

      // reset with a full buffer discards everything
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 17'h1FFFF; in_mode = 2'd0;
      step(); step();
      chk("pre_rst_full", 32'(in_ready), 32'd0);
      reset = 1'b1;
      #1;
      chk("rst_blocks_ready", 32'(in_ready), 32'd0);
      step();
      reset = 1'b0; in_valid = 1'b0;
      #1;
      chk("midrst_valid", 32'(out_valid), 32'd0);
      chk("midrst_data", out_data, 32'h0);
      chk("midrst_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      step(); step();
      chk("midrst_no_stale", 32'(out_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
